// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: runs one single-beat bus cycle per accepted command
// and returns the read data or a timeout error on a valid/ready response channel.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8,
    parameter int ERRCNT_W       = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [31:0]         cmd_adr,
    input  logic [31:0]         cmd_dat,
    input  logic [3:0]          cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [3:0]          wbm_sel_o,
    output logic [31:0]         wbm_adr_o,
    output logic [31:0]         wbm_dat_o,
    input  logic [31:0]         wbm_dat_i,
    input  logic                wbm_ack_i,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Terminal count of the STB watchdog; only meaningful when the timeout is enabled.
    localparam logic [TIMEOUT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES != 0) ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t               state;
    logic [TIMEOUT_W-1:0] to_cnt;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            busy      <= 1'b0;
            err_count <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        to_cnt    <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // ACK takes priority over a watchdog expiry on the same edge.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST)) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        err_count <= sat_inc(err_count);
                        state     <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with an 8-cycle timeout and an 8-bit error counter.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        busy;
    logic [7:0]  err_count;

    int passed = 0;
    int total  = 0;

    wb_cmd_master #(
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_W(8),
        .ERRCNT_W(8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .busy     (busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        int n;
        int bad;

        // Reset state
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cyc_stb",   32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'd0);
        check("rst_adr",       wbm_adr_o, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);

        // Write with zero-wait ACK; bus read data must not leak into rsp_dat
        wbm_dat_i = 32'hDEAD_BEEF;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004;
        cmd_dat = 32'hA5A5_1234; cmd_sel = 4'hF;
        step();
        cmd_valid = 1'b0;
        check("wr_cyc_stb",   32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
        check("wr_we",        32'(wbm_we_o), 32'd1);
        check("wr_adr",       wbm_adr_o, 32'h3000_0004);
        check("wr_dat",       wbm_dat_o, 32'hA5A5_1234);
        check("wr_sel",       32'(wbm_sel_o), 32'hF);
        check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
        check("wr_busy",      32'(busy), 32'd1);
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_err",   32'(rsp_err), 32'd0);
        check("wr_rsp_dat",   rsp_dat, 32'd0);
        check("wr_cyc_drop",  32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wr_done_valid", 32'(rsp_valid), 32'd0);
        check("wr_done_ready", 32'(cmd_ready), 32'd1);

        // Read with 3 wait states
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010; cmd_sel = 4'h3;
        step();
        cmd_valid = 1'b0;
        check("rd_we",  32'(wbm_we_o), 32'd0);
        check("rd_sel", 32'(wbm_sel_o), 32'h3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_stb_%0d", i), 32'({wbm_cyc_o, wbm_stb_o, rsp_valid}), 32'd6);
            if (i == 3) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'hCAFE_F00D;
            end
            step();
        end
        wbm_ack_i = 1'b0;
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_dat",   rsp_dat, 32'hCAFE_F00D);
        check("rd_rsp_err",   32'(rsp_err), 32'd0);
        check("rd_cyc_drop",  32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Timeout: STB high for exactly 8 cycles
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_stb_%0d", i), 32'({wbm_stb_o, rsp_valid}), 32'd2);
            step();
        end
        check("to_stb_drop",  32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err",   32'(rsp_err), 32'd1);
        check("to_rsp_dat",   rsp_dat, 32'd0);
        check("to_err_count", 32'(err_count), 32'd1);
        // Late ACK in RESP is ignored
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
        step();
        check("late_ack_dat", rsp_dat, 32'd0);
        check("late_ack_err", 32'({rsp_valid, rsp_err, wbm_cyc_o}), 32'd6);
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        step();
        // rsp_ready with nothing pending and a stray ACK in IDLE: no effect
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;
        check("idle_stray", 32'({rsp_valid, wbm_cyc_o, cmd_ready, busy}), 32'd2);
        check("idle_rsp_dat_kept", rsp_dat, 32'd0);

        // ACK on the terminal-count edge wins
        cmd_valid = 1'b1; cmd_adr = 32'h3000_0024;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h1122_3344;
            end
            step();
        end
        wbm_ack_i = 1'b0;
        check("tc_ack_err",   32'(rsp_err), 32'd0);
        check("tc_ack_dat",   rsp_dat, 32'h1122_3344);
        check("tc_err_count", 32'(err_count), 32'd1);

        // Backpressure: response held, new command waits
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0030;
        cmd_dat = 32'h0BAD_F00D; cmd_sel = 4'hC;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_hold_%0d", i),
                  32'({rsp_valid, rsp_err, cmd_ready, wbm_cyc_o}), 32'h8);
            check($sformatf("bp_dat_%0d", i), rsp_dat, 32'h1122_3344);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_idle", 32'({cmd_ready, wbm_cyc_o, rsp_valid}), 32'h4);
        step();
        cmd_valid = 1'b0;
        check("bp_accept_adr", wbm_adr_o, 32'h3000_0030);
        check("bp_accept_cyc", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'd7);

        // Reset in the second BUS cycle
        step();
        check("mid_bus_stb", 32'(wbm_stb_o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_bus", 32'({wbm_cyc_o, wbm_stb_o, rsp_valid}), 32'd0);
        check("mid_rst_ctl", 32'({cmd_ready, busy}), 32'h2);
        check("mid_rst_errcnt", 32'(err_count), 32'd0);

        // 300 timeouts saturate err_count at 255
        bad = 0;
        cmd_we = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            n = 0;
            while (!rsp_valid && n < 20) begin
                step();
                n++;
            end
            if (!rsp_valid || !rsp_err) bad++;
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            if (i == 253) check("sat_254", 32'(err_count), 32'd254);
        end
        check("sat_loop_responses", 32'(bad), 32'd0);
        check("sat_err_count", 32'(err_count), 32'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic initiator inside the user project area. It is the opposite end of the wrapper's Wishbone slave port.
- Accepts single-beat read/write commands on a valid/ready interface and runs one Wishbone cycle per command.
- Returns read data, or a timeout error, on a valid/ready response interface.
- Drives on-chip Wishbone slaves (peripheral register banks) from a local sequencer, independent of the management SoC.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles STB stays asserted without ACK before abort; 0 disables timeout
TIMEOUT_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES
ERRCNT_W, 8, width of saturating error counter

Ports:
wb_clk_i  input  1  sole clock
wb_rst_i  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid&&ready
cmd_we  input  1  1=write, 0=read
cmd_adr  input  32  byte address
cmd_dat  input  32  write data
cmd_sel  input  4  byte selects
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when valid&&ready
rsp_dat  output  32  read data; 0 for writes and errors
rsp_err  output  1  1=timeout abort
wbm_cyc_o  output  1  Wishbone CYC
wbm_stb_o  output  1  Wishbone STB
wbm_we_o  output  1  Wishbone WE
wbm_sel_o  output  4  Wishbone SEL
wbm_adr_o  output  32  Wishbone ADR
wbm_dat_o  output  32  Wishbone write data
wbm_dat_i  input  32  Wishbone read data
wbm_ack_i  input  1  Wishbone ACK
busy  output  1  high whenever state != IDLE
err_count  output  ERRCNT_W  saturating count of timeouts

Behaviour:
- Clock and reset: single clock wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: state=IDLE; cmd_ready=1 from the first cycle after reset; rsp_valid=0, rsp_err=0, rsp_dat=0; wbm_cyc_o=wbm_stb_o=wbm_we_o=0; wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0; err_count=0; timeout counter=0.
- Registered outputs: all outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE: cmd_ready=1. On edge with cmd_valid: latch we/adr/dat/sel into the wbm_* registers, set cyc=stb=1, clear timeout counter, go BUS.
  - BUS: cmd_ready=0; cyc=stb=1; wbm_adr/dat/sel/we held stable.
    - On an edge with wbm_ack_i=1: cyc=stb=0; rsp_dat = read ? wbm_dat_i : 0; rsp_err=0; rsp_valid=1; go RESP.
    - Otherwise, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: cyc=stb=0; rsp_dat=0; rsp_err=1; rsp_valid=1; err_count+=1, saturating at all-ones; go RESP.
    - Otherwise counter+=1.
  - RESP: cmd_ready=0; rsp_* held stable. On edge with rsp_ready: rsp_valid=0, go IDLE (cmd_ready=1 next cycle).
- Latency: command accepted at edge N → STB high in cycle N+1. A slave ACKing in that cycle gives rsp_valid high in cycle N+2. Back-to-back commands need at least 1 IDLE cycle.
- Timeout: STB is high for exactly TIMEOUT_CYCLES cycles when no ACK arrives.
- Boundary conditions:
  - ACK on the same edge as the timeout terminal count: ACK wins; normal response, no error counted.
  - ACK in IDLE or RESP (stray or late ACK): ignored; no state change, no data capture.
  - cmd_valid in BUS or RESP: not accepted; the command must be held by its source.
  - rsp_ready asserted while rsp_valid=0: no effect.
  - Reset mid-transaction: cyc/stb drop at that edge; the pending response is discarded; err_count clears.
- Only one outstanding transaction; no pipelining, no bursts (CTI/BTE not used).

Test Plan:
- Write, zero-wait ACK: cmd we=1 adr=0x3000_0004 dat=0xA5A5_1234 sel=0xF → one STB cycle with those values on wbm_*; rsp_valid 2 cycles after accept; rsp_err=0; rsp_dat=0.
- Read with 3 wait states: slave ACKs on 4th STB cycle with dat_i=0xCAFE_F00D → cyc/stb high 4 cycles; rsp_dat=0xCAFE_F00D; rsp_err=0.
- Timeout, TIMEOUT_CYCLES=8, no ACK → STB high exactly 8 cycles; rsp_err=1; rsp_dat=0; err_count=1. A later ACK is ignored.
- ACK exactly at cycle 8 with TIMEOUT_CYCLES=8 → normal response; rsp_err=0; err_count unchanged.
- Response backpressure: rsp_ready held 0 for 5 cycles with cmd_valid held 1 → rsp_* stable and cmd_ready=0 throughout. Second command accepted only in the IDLE cycle after rsp_ready.
- Reset asserted in the 2nd BUS cycle → cyc/stb=0 and rsp_valid=0 next cycle; cmd_ready=1; err_count=0. 300 timeouts with ERRCNT_W=8 saturate err_count at 255.
